// File: rtl/aes_pkg.sv
// aes_pkg -- shared definitions for the iterative AES-128 cipher.
//   Key-expander state encodings, encryption FSM encodings, round and
//   key-slot counts, the GF(2^8) reduction constant, and the xtime,
//   field-multiply and S-box functions used by the round logic.
package aes_pkg;

    localparam logic [3:0] NR       = 4'd10;   // AES-128 round count, fixed
    localparam int         NK_SLOTS = 11;      // round keys 0..10
    localparam logic [7:0] RED_POLY = 8'h1B;   // x^8 = x^4 + x^3 + x + 1
    localparam logic [7:0] INV_EXP  = 8'd254;  // b^254 = b^-1 in GF(2^8)

    typedef enum logic [1:0] {
        KS_IDLE      = 2'b00,
        KS_ROUND0    = 2'b01,
        KS_ROUND1TO9 = 2'b10,
        KS_ROUND10   = 2'b11
    } key_state_t;

    typedef enum logic {
        FSM_IDLE = 1'b0,
        FSM_RUN  = 1'b1
    } fsm_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RED_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (square-and-multiply to b^254, which
    // maps 0 to 0) followed by the affine transform with constant 0x63.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (INV_EXP[i]) r = gf_mul(r, b);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_round.sv
// aes_round -- one combinational AES encryption round.
//   state      in  128  current state, column 0 in [127:96], row 0 in the MSB byte
//   round_key  in  128  round key, same layout
//   last_round in  1    skip MixColumns (final round)
//   result     out 128  SubBytes/ShiftRows/[MixColumns]/AddRoundKey of state
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic [127:0] result
);

    logic [7:0] sb [4][4];   // [column][row]
    logic [7:0] sr [4][4];
    logic [7:0] mc [4][4];

    // NOTE: every combinational output gets a default before any conditional
    // logic so no path leaves it unassigned (which would infer a latch), and
    // combinational blocks use blocking assignments so later lines see the
    // values computed above them.
    always_comb begin
        result = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sb[c][r] = sbox(state[127 - 32*c - 8*r -: 8]);
            end
        end
        // Row r rotates left by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[c][r] = sb[(c + r) % 4][r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[c][0] = xtime(sr[c][0]) ^ xtime(sr[c][1]) ^ sr[c][1] ^ sr[c][2] ^ sr[c][3];
            mc[c][1] = sr[c][0] ^ xtime(sr[c][1]) ^ xtime(sr[c][2]) ^ sr[c][2] ^ sr[c][3];
            mc[c][2] = sr[c][0] ^ sr[c][1] ^ xtime(sr[c][2]) ^ xtime(sr[c][3]) ^ sr[c][3];
            mc[c][3] = xtime(sr[c][0]) ^ sr[c][0] ^ sr[c][1] ^ sr[c][2] ^ xtime(sr[c][3]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                result[127 - 32*c - 8*r -: 8] = (last_round ? sr[c][r] : mc[c][r])
                                                ^ round_key[127 - 32*c - 8*r -: 8];
            end
        end
    end

endmodule

// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter -- iterative AES-128 encryption, one round per clock.
//   CLK                 in   clock, rising edge
//   RST                 in   asynchronous active-low reset
//   key_state_in[1:0]   in   key expander state (IDLE/ROUND0/ROUND1TO9/ROUND10)
//   key0_in..key3_in    in   current round key columns
//   start_in            in   encryption request (taken only when idle and keys ready)
//   data0_in..data3_in  in   plaintext columns
//   data0_out..data3_out out ciphertext columns
//   done_out            out  one-cycle ciphertext-valid pulse
//   busy_out            out  encryption in progress
//   key_ready_out       out  all 11 round keys captured
// Build option: define AES_CIPHER_ZEROIZE_EN to blank data*_out outside the
// done cycle and clear the state register on completion and abort.
module aes_cipher_iter
    import aes_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  key_state_in,
    input  logic [31:0] key0_in,
    input  logic [31:0] key1_in,
    input  logic [31:0] key2_in,
    input  logic [31:0] key3_in,
    input  logic        start_in,
    input  logic [31:0] data0_in,
    input  logic [31:0] data1_in,
    input  logic [31:0] data2_in,
    input  logic [31:0] data3_in,
    output logic [31:0] data0_out,
    output logic [31:0] data1_out,
    output logic [31:0] data2_out,
    output logic [31:0] data3_out,
    output logic        done_out,
    output logic        busy_out,
    output logic        key_ready_out
);

    logic [127:0] key_word;
    logic [127:0] data_word;
    logic [127:0] rk [NK_SLOTS];
    key_state_t   ks_prev;
    logic [3:0]   slot_ptr;
    logic         load_start;

    fsm_state_t   fsm;
    logic [3:0]   round_cnt;
    logic [127:0] st;
    logic [127:0] round_res;
    logic [127:0] data_q;

    assign key_word   = {key0_in, key1_in, key2_in, key3_in};
    assign data_word  = {data0_in, data1_in, data2_in, data3_in};
    assign load_start = (key_state_in == KS_ROUND0) && (ks_prev == KS_IDLE);

    // Key capture: slot 0 on the first ROUND0 cycle, slots 1..9 in order
    // during ROUND1TO9, slot 10 on ROUND10.
    // NOTE: the key store is reset explicitly so no stale key survives a reset
    // even though it is wide; sequential blocks use non-blocking assignments
    // so every register updates from pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ks_prev       <= KS_IDLE;
            slot_ptr      <= 4'd0;
            key_ready_out <= 1'b0;
            for (int i = 0; i < NK_SLOTS; i++) rk[i] <= '0;
        end else begin
            ks_prev <= key_state_t'(key_state_in);
            case (key_state_in)
                KS_ROUND0: begin
                    if (ks_prev == KS_IDLE) begin
                        rk[0]         <= key_word;
                        slot_ptr      <= 4'd1;
                        key_ready_out <= 1'b0;
                    end
                end
                KS_ROUND1TO9: begin
                    // Extra ROUND1TO9 cycles beyond slot 9 are dropped.
                    if (slot_ptr >= 4'd1 && slot_ptr <= 4'd9) begin
                        rk[slot_ptr] <= key_word;
                        slot_ptr     <= slot_ptr + 4'd1;
                    end
                end
                KS_ROUND10: begin
                    rk[NR]        <= key_word;
                    key_ready_out <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    aes_round u_round (
        .state      (st),
        .round_key  (rk[round_cnt]),
        .last_round (round_cnt == NR),
        .result     (round_res)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fsm       <= FSM_IDLE;
            round_cnt <= 4'd0;
            st        <= '0;
            data_q    <= '0;
            done_out  <= 1'b0;
            busy_out  <= 1'b0;
        end else begin
            done_out <= 1'b0;
`ifdef AES_CIPHER_ZEROIZE_EN
            data_q <= '0;
`endif
            case (fsm)
                FSM_IDLE: begin
                    // A key load starting in this very cycle overwrites rk[0];
                    // refuse the request rather than start on a dying key set.
                    if (start_in && key_ready_out && !load_start) begin
                        st        <= data_word ^ rk[0];
                        round_cnt <= 4'd1;
                        fsm       <= FSM_RUN;
                        busy_out  <= 1'b1;
                    end
                end
                FSM_RUN: begin
                    if (load_start) begin
                        fsm       <= FSM_IDLE;
                        round_cnt <= 4'd0;
                        busy_out  <= 1'b0;
`ifdef AES_CIPHER_ZEROIZE_EN
                        st <= '0;
`endif
                    end else if (round_cnt == NR) begin
                        data_q    <= round_res;
                        done_out  <= 1'b1;
                        fsm       <= FSM_IDLE;
                        round_cnt <= 4'd0;
                        busy_out  <= 1'b0;
`ifdef AES_CIPHER_ZEROIZE_EN
                        st <= '0;
`else
                        st <= round_res;
`endif
                    end else begin
                        st        <= round_res;
                        round_cnt <= round_cnt + 4'd1;
                    end
                end
                default: fsm <= FSM_IDLE;
            endcase
        end
    end

    assign data0_out = data_q[127:96];
    assign data1_out = data_q[95:64];
    assign data2_out = data_q[63:32];
    assign data3_out = data_q[31:0];

endmodule

// File: tb/tb_aes_cipher_iter.sv
// tb_aes_cipher_iter -- self-checking bench for aes_cipher_iter.
//   Known-answer table (FIPS-197), random keys/blocks against a byte-array
//   AES reference model, plus sequences for held start, back-to-back blocks,
//   abort by key reload and asynchronous reset mid-encryption.
module tb_aes_cipher_iter;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  key_state_in;
    logic [31:0] key0_in, key1_in, key2_in, key3_in;
    logic        start_in;
    logic [31:0] data0_in, data1_in, data2_in, data3_in;
    logic [31:0] data0_out, data1_out, data2_out, data3_out;
    logic        done_out, busy_out, key_ready_out;
    logic [127:0] dout;

    aes_cipher_iter dut (
        .CLK(CLK), .RST(RST), .key_state_in(key_state_in),
        .key0_in(key0_in), .key1_in(key1_in), .key2_in(key2_in), .key3_in(key3_in),
        .start_in(start_in),
        .data0_in(data0_in), .data1_in(data1_in), .data2_in(data2_in), .data3_in(data3_in),
        .data0_out(data0_out), .data1_out(data1_out), .data2_out(data2_out), .data3_out(data3_out),
        .done_out(done_out), .busy_out(busy_out), .key_ready_out(key_ready_out)
    );

    always #5 CLK = ~CLK;
    assign dout = {data0_out, data1_out, data2_out, data3_out};

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    logic [7:0]   sb_tab [256];
    logic [127:0] mrk [11];
    logic [127:0] last_ct = '0;

    // Carry-less product followed by polynomial long division by 0x11B.
    function automatic logic [7:0] gmul_ref(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011B << (i - 8));
        return prod[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul_ref(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb_tab[x] = s;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
                t = t ^ {rcon, 24'h0};
                rcon = gmul_ref(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] enc_ref(input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] out;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ mrk[0][127 - 8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c + r] = t[4*((c + r) % 4) + r];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul_ref(a0, 8'h02) ^ gmul_ref(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul_ref(a1, 8'h02) ^ gmul_ref(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul_ref(a2, 8'h02) ^ gmul_ref(a3, 8'h03);
                    s[4*c+3] = gmul_ref(a0, 8'h03) ^ a1 ^ a2 ^ gmul_ref(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ mrk[rnd][127 - 8*i -: 8];
        end
        for (int i = 0; i < 16; i++) out[127 - 8*i -: 8] = s[i];
        return out;
    endfunction

    // ---------------- bench helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] held_value();
`ifdef AES_CIPHER_ZEROIZE_EN
        return '0;
`else
        return last_ct;
`endif
    endfunction

    task automatic set_key(input logic [127:0] k);
        {key0_in, key1_in, key2_in, key3_in} = k;
    endtask

    task automatic set_data(input logic [127:0] d);
        {data0_in, data1_in, data2_in, data3_in} = d;
    endtask

    // Streams the round keys like the expander: one IDLE cycle, two ROUND0
    // cycles (the second carries junk that must be ignored), nine ROUND1TO9,
    // one ROUND10. Returns in the cycle after ROUND10.
    task automatic load_keys(input logic [127:0] key);
        int n_done;
        n_done = 0;
        expand_key(key);
        key_state_in = 2'b00; tick();
        if (done_out) n_done++;
        key_state_in = 2'b01; set_key(mrk[0]); tick();
        if (done_out) n_done++;
        check("key_ready cleared at load start", 128'(key_ready_out), 128'(0));
        check("busy low after load start", 128'(busy_out), 128'(0));
        key_state_in = 2'b01; set_key(~mrk[0]); tick();
        if (done_out) n_done++;
        for (int r = 1; r <= 9; r++) begin
            key_state_in = 2'b10; set_key(mrk[r]); tick();
            if (done_out) n_done++;
        end
        check("key_ready low before slot 10", 128'(key_ready_out), 128'(0));
        key_state_in = 2'b11; set_key(mrk[10]); tick();
        if (done_out) n_done++;
        key_state_in = 2'b00; set_key(rand128());
        check("key_ready after slot 10", 128'(key_ready_out), 128'(1));
        check("no done during key load", 128'(n_done), 128'(0));
    endtask

    // Issues a request in the current cycle T and returns in cycle T+11.
    task automatic enc(input logic [127:0] pt, input logic [127:0] exp, input string name);
        int n_err;
        n_err = 0;
        set_data(pt); start_in = 1'b1; tick(); start_in = 1'b0;
        set_data(rand128());
        for (int i = 1; i <= 10; i++) begin
            if (!busy_out || done_out) n_err++;
            tick();
        end
        check({name, " busy T+1..T+10"}, 128'(n_err), 128'(0));
        check({name, " done/busy at T+11"}, 128'({done_out, busy_out}), 128'(2'b10));
        check({name, " ciphertext"}, dout, exp);
        last_ct = exp;
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } kat_t;

    kat_t kat [2];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_err;
        logic [127:0] k, pt, exp;

        kat[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                   128'h3243f6a8885a308d313198a2e0370734,
                   128'h3925841d02dc09fbdc118597196a0b32};
        kat[1] = '{128'h000102030405060708090a0b0c0d0e0f,
                   128'h00112233445566778899aabbccddeeff,
                   128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        build_sbox();

        RST = 1'b0; key_state_in = 2'b00; start_in = 1'b0;
        set_key('0); set_data('0);
        repeat (3) tick();
        check("reset outputs", {dout, 3'b0, done_out, busy_out, key_ready_out}, '0);
        RST = 1'b1;

        // Requests before any key load are ignored.
        start_in = 1'b1; repeat (3) tick(); start_in = 1'b0;
        check("start ignored without keys", 128'(busy_out), 128'(0));

        // Known-answer table.
        for (int i = 0; i < 2; i++) begin
            load_keys(kat[i].key);
            tick();
            enc(kat[i].pt, kat[i].ct, $sformatf("kat%0d", i));
        end

        // Back-to-back: second request in the done cycle of the first.
        enc(kat[1].pt, kat[1].ct, "b2b first");
        pt = rand128();
        enc(pt, enc_ref(pt), "b2b second");
        tick();
        check("done is one pulse", 128'(done_out), 128'(0));
        check("output held after done", dout, held_value());

        // Random keys and blocks against the model.
        for (int kk = 0; kk < 2; kk++) begin
            k = rand128();
            load_keys(k);
            for (int b = 0; b < 3; b++) begin
                pt = rand128();
                enc(pt, enc_ref(pt), $sformatf("rand k%0d b%0d", kk, b));
            end
            repeat ($urandom_range(0, 3)) tick();
        end

        // Key reload during RUN: ROUND0 lands in T+5 and aborts the block.
        tick();
        set_data(rand128()); start_in = 1'b1; tick(); start_in = 1'b0;
        n_err = 0;
        repeat (3) begin
            if (done_out) n_err++;
            tick();
        end
        check("no done before abort", 128'(n_err), 128'(0));
        k = rand128();
        load_keys(k);
        check("output retained after abort", dout, held_value());
        pt = rand128();
        enc(pt, enc_ref(pt), "after reload");

        // Asynchronous reset at T+4.
        tick();
        set_data(rand128()); start_in = 1'b1; tick(); start_in = 1'b0;
        repeat (3) tick();
        #2 RST = 1'b0;
        #1 check("async reset clears outputs",
                 {dout, 3'b0, done_out, busy_out, key_ready_out}, '0);
        #1 RST = 1'b1;
        last_ct = '0;

        // start held across the reload: accepted only once keys are ready.
        start_in = 1'b1; set_data(kat[0].pt);
        n_err = 0;
        repeat (4) begin
            tick();
            if (busy_out) n_err++;
        end
        check("start ignored after reset", 128'(n_err), 128'(0));
        load_keys(kat[0].key);
        set_data(kat[0].pt);
        check("not yet accepted when key_ready rises", 128'(busy_out), 128'(0));
        tick();
        set_data(rand128());
        n_err = 0;
        for (int i = 1; i <= 10; i++) begin
            if (!busy_out || done_out) n_err++;
            tick();
        end
        start_in = 1'b0;
        check("held start busy window", 128'(n_err), 128'(0));
        check("held start done", 128'({done_out, busy_out}), 128'(2'b10));
        check("held start ciphertext", dout, kat[0].ct);
        last_ct = kat[0].ct;
        n_err = 0;
        repeat (12) begin
            tick();
            if (done_out || busy_out) n_err++;
        end
        check("single done for held start", 128'(n_err), 128'(0));
        exp = held_value();
        check("final output hold", dout, exp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
